// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : CDB transmit end: per-FU result FIFOs, round-robin grant, one
//            registered broadcast per cycle. Option macro: CDB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int QDEPTH    = 2,
  parameter int ROB_TAG_W = 3,
  parameter int RS_TAG_W  = 3,
  parameter int XLEN      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash_i,
  input  logic [NUM_FU-1:0]             fu_valid_i,
  output logic [NUM_FU-1:0]             fu_ready_o,
  input  logic [NUM_FU*ROB_TAG_W-1:0]   fu_rob_tag_i,
  input  logic [NUM_FU*RS_TAG_W-1:0]    fu_rs_tag_i,
  input  logic [NUM_FU*XLEN-1:0]        fu_value_i,
  output logic                          cdb_valid_o,
  output logic [ROB_TAG_W-1:0]          cdb_rob_tag_o,
  output logic [RS_TAG_W-1:0]           cdb_rs_tag_o,
  output logic [XLEN-1:0]               cdb_value_o,
  output logic [$clog2(NUM_FU)-1:0]     cdb_src_o
);

  localparam int SRC_W = $clog2(NUM_FU);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0]    FULL_CNT   = CNT_W'(QDEPTH);
  localparam logic [RS_TAG_W-1:0] RS_INVALID = '1;

  logic [NUM_FU-1:0][ROB_TAG_W-1:0] w_in_rob;
  logic [NUM_FU-1:0][RS_TAG_W-1:0]  w_in_rs;
  logic [NUM_FU-1:0][XLEN-1:0]      w_in_val;
  logic [NUM_FU-1:0][ROB_TAG_W-1:0] w_head_rob;
  logic [NUM_FU-1:0][RS_TAG_W-1:0]  w_head_rs;
  logic [NUM_FU-1:0][XLEN-1:0]      w_head_val;

  logic [NUM_FU-1:0] w_nonempty;
  logic [NUM_FU-1:0] w_accept;
  logic [NUM_FU-1:0] w_live;
  logic [NUM_FU-1:0] w_cand;
  logic [NUM_FU-1:0] w_grant;
  logic [NUM_FU-1:0] w_enq;
  logic [NUM_FU-1:0] w_deq;

  logic                 w_found;
  logic [SRC_W-1:0]     w_win;
  logic [ROB_TAG_W-1:0] w_sel_rob;
  logic [RS_TAG_W-1:0]  w_sel_rs;
  logic [XLEN-1:0]      w_sel_val;

  logic [SRC_W-1:0]     rr_q, rr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_TAG_W-1:0] cdb_rob_tag_q, cdb_rob_tag_d;
  logic [RS_TAG_W-1:0]  cdb_rs_tag_q, cdb_rs_tag_d;
  logic [XLEN-1:0]      cdb_value_q, cdb_value_d;
  logic [SRC_W-1:0]     cdb_src_q, cdb_src_d;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [ROB_TAG_W-1:0] rob_mem_q [QDEPTH];
    logic [RS_TAG_W-1:0]  rs_mem_q  [QDEPTH];
    logic [XLEN-1:0]      val_mem_q [QDEPTH];

    assign w_in_rob[gi] = fu_rob_tag_i[gi*ROB_TAG_W +: ROB_TAG_W];
    assign w_in_rs[gi]  = fu_rs_tag_i[gi*RS_TAG_W +: RS_TAG_W];
    assign w_in_val[gi] = fu_value_i[gi*XLEN +: XLEN];

    // Ready comes from the occupancy register alone, never from fu_valid.
    assign fu_ready_o[gi] = (count_q != FULL_CNT);
    assign w_nonempty[gi] = (count_q != '0);

    assign w_accept[gi] = fu_valid_i[gi] & fu_ready_o[gi] & ~squash_i;
    // A reserved ROB tag is handshaken but never stored or broadcast.
    assign w_live[gi]   = w_accept[gi] & (w_in_rob[gi] != '0);

`ifdef CDB_BYPASS_EN
    assign w_cand[gi] = w_nonempty[gi] | w_live[gi];
`else
    assign w_cand[gi] = w_nonempty[gi];
`endif

    assign w_grant[gi] = w_found & (w_win == SRC_W'(gi)) & ~squash_i;
    assign w_deq[gi]   = w_grant[gi] & w_nonempty[gi];
    assign w_enq[gi]   = w_live[gi] & ~(w_grant[gi] & ~w_nonempty[gi]);

    assign w_head_rob[gi] = rob_mem_q[rd_ptr_q];
    assign w_head_rs[gi]  = rs_mem_q[rd_ptr_q];
    assign w_head_val[gi] = val_mem_q[rd_ptr_q];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else if (squash_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (w_enq[gi]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (w_deq[gi]) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (w_enq[gi] && !w_deq[gi]) begin
          count_q <= count_q + CNT_W'(1);
        end else if (!w_enq[gi] && w_deq[gi]) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clock) begin
      if (w_enq[gi]) begin
        rob_mem_q[wr_ptr_q] <= w_in_rob[gi];
        rs_mem_q[wr_ptr_q]  <= w_in_rs[gi];
        val_mem_q[wr_ptr_q] <= w_in_val[gi];
      end
    end
  end

  // First candidate at or after rr_q; NUM_FU is a power of two so the sum wraps.
  always_comb begin
    logic [SRC_W-1:0] w_idx;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_idx = rr_q + SRC_W'(k);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_rob = w_head_rob[w_win];
    w_sel_rs  = w_head_rs[w_win];
    w_sel_val = w_head_val[w_win];
`ifdef CDB_BYPASS_EN
    if (!w_nonempty[w_win]) begin
      w_sel_rob = w_in_rob[w_win];
      w_sel_rs  = w_in_rs[w_win];
      w_sel_val = w_in_val[w_win];
    end
`endif
  end

  // Idle or squashed cycles drive tag 0 so no receiver can match a live entry.
  always_comb begin
    cdb_valid_d   = 1'b0;
    cdb_rob_tag_d = '0;
    cdb_rs_tag_d  = RS_INVALID;
    cdb_value_d   = cdb_value_q;
    cdb_src_d     = cdb_src_q;
    rr_d          = rr_q;
    if (w_found && !squash_i) begin
      cdb_valid_d   = 1'b1;
      cdb_rob_tag_d = w_sel_rob;
      cdb_rs_tag_d  = w_sel_rs;
      cdb_value_d   = w_sel_val;
      cdb_src_d     = w_win;
      rr_d          = w_win + SRC_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q          <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_rob_tag_q <= '0;
      cdb_rs_tag_q  <= RS_INVALID;
      cdb_value_q   <= '0;
      cdb_src_q     <= '0;
    end else begin
      rr_q          <= rr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_tag_q <= cdb_rob_tag_d;
      cdb_rs_tag_q  <= cdb_rs_tag_d;
      cdb_value_q   <= cdb_value_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  assign cdb_valid_o   = cdb_valid_q;
  assign cdb_rob_tag_o = cdb_rob_tag_q;
  assign cdb_rs_tag_o  = cdb_rs_tag_q;
  assign cdb_value_o   = cdb_value_q;
  assign cdb_src_o     = cdb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Scoreboard bench for cdb_arbiter (default build, 2-cycle latency).
// Revision : 1.0
// ============================================================================
module tb_cdb_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic         squash;
  logic [3:0]   fu_valid;
  logic [3:0]   fu_ready;
  logic [11:0]  fu_rob_tag;
  logic [11:0]  fu_rs_tag;
  logic [127:0] fu_value;
  logic         cdb_valid;
  logic [2:0]   cdb_rob_tag;
  logic [2:0]   cdb_rs_tag;
  logic [31:0]  cdb_value;
  logic [1:0]   cdb_src;

  cdb_arbiter #(
    .NUM_FU(4), .QDEPTH(2), .ROB_TAG_W(3), .RS_TAG_W(3), .XLEN(32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .squash_i      (squash),
    .fu_valid_i    (fu_valid),
    .fu_ready_o    (fu_ready),
    .fu_rob_tag_i  (fu_rob_tag),
    .fu_rs_tag_i   (fu_rs_tag),
    .fu_value_i    (fu_value),
    .cdb_valid_o   (cdb_valid),
    .cdb_rob_tag_o (cdb_rob_tag),
    .cdb_rs_tag_o  (cdb_rs_tag),
    .cdb_value_o   (cdb_value),
    .cdb_src_o     (cdb_src)
  );

  always #5 clock = ~clock;

  logic [31:0] cyc = 32'd0;
  always @(posedge clock) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic [2:0]  rob;
    logic [2:0]  rs;
    logic [31:0] val;
    logic [1:0]  src;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: every broadcast must match the oldest expected entry, cycle included.
  always @(negedge clock) begin
    if (!reset && cdb_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_bcast: got rob=%0d rs=%0d val=%h src=%0d cyc=%0d, required no broadcast",
                 cdb_rob_tag, cdb_rs_tag, cdb_value, cdb_src, cyc);
      end else begin
        m_e = exp_q.pop_front();
        if (cdb_rob_tag === m_e.rob && cdb_rs_tag === m_e.rs && cdb_value === m_e.val &&
            cdb_src === m_e.src && cyc === m_e.cyc) begin
          n_pass++;
        end else begin
          $display("FAIL bcast: got rob=%0d rs=%0d val=%h src=%0d cyc=%0d, required rob=%0d rs=%0d val=%h src=%0d cyc=%0d",
                   cdb_rob_tag, cdb_rs_tag, cdb_value, cdb_src, cyc,
                   m_e.rob, m_e.rs, m_e.val, m_e.src, m_e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    fu_valid   = '0;
    fu_rob_tag = '0;
    fu_rs_tag  = '0;
    fu_value   = '0;
  endtask

  task automatic drive(input int f, input logic [2:0] rob, input logic [2:0] rs, input logic [31:0] v);
    fu_valid[f]          = 1'b1;
    fu_rob_tag[f*3 +: 3] = rob;
    fu_rs_tag[f*3 +: 3]  = rs;
    fu_value[f*32 +: 32] = v;
  endtask

  task automatic expect_b(input logic [2:0] rob, input logic [2:0] rs, input logic [31:0] v,
                          input logic [1:0] src, input logic [31:0] c);
    exp_t e;
    e.rob = rob; e.rs = rs; e.val = v; e.src = src; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL drain: %0d broadcasts outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] b;

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    clr();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_rob",   64'(cdb_rob_tag), 64'd0);
    chk("rst_rs",    64'(cdb_rs_tag), 64'd7);
    chk("rst_value", 64'(cdb_value), 64'd0);
    chk("rst_src",   64'(cdb_src), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", 64'(fu_ready), 64'hF);

    // Single result, 2-cycle latency, single-cycle pulse
    tick(); b = cyc; clr();
    drive(1, 3'd3, 3'd1, 32'hDEAD);
    expect_b(3'd3, 3'd1, 32'hDEAD, 2'd1, b + 2);
    tick(); clr();
    tick(); tick();
    @(negedge clock);
    chk("single_pulse", 64'(cdb_valid), 64'd0);
    drain(5);

    // Reset while broadcasting (rr_ptr=2: FU3 first); queued results are lost
    tick(); b = cyc; clr();
    drive(0, 3'd5, 3'd0, 32'h0A0);
    drive(1, 3'd6, 3'd1, 32'h0A1);
    drive(3, 3'd7, 3'd3, 32'h0A3);
    expect_b(3'd7, 3'd3, 32'h0A3, 2'd3, b + 2);
    tick(); clr();
    tick();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(cdb_valid), 64'd0);
    chk("midrst_rs",    64'(cdb_rs_tag), 64'd7);
    chk("midrst_rob",   64'(cdb_rob_tag), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ready", 64'(fu_ready), 64'hF);
    repeat (4) tick();
    drain(1);

    // Round robin after reset: 0, 2, 3
    tick(); b = cyc; clr();
    drive(0, 3'd1, 3'd0, 32'hB0);
    drive(2, 3'd2, 3'd2, 32'hB2);
    drive(3, 3'd3, 3'd3, 32'hB3);
    expect_b(3'd1, 3'd0, 32'hB0, 2'd0, b + 2);
    expect_b(3'd2, 3'd2, 32'hB2, 2'd2, b + 3);
    expect_b(3'd3, 3'd3, 32'hB3, 2'd3, b + 4);
    tick(); clr();
    drain(10);

    // Rotation and wrap: FU2 sets rr=3, then 3, 0, then 1, 2, 1
    tick(); b = cyc; clr();
    drive(2, 3'd2, 3'd2, 32'h22);
    expect_b(3'd2, 3'd2, 32'h22, 2'd2, b + 2);
    tick(); clr();
    drive(3, 3'd5, 3'd3, 32'h33);
    drive(0, 3'd4, 3'd0, 32'h44);
    expect_b(3'd5, 3'd3, 32'h33, 2'd3, b + 3);
    expect_b(3'd4, 3'd0, 32'h44, 2'd0, b + 4);
    tick(); clr();
    drive(1, 3'd6, 3'd4, 32'h11A);
    expect_b(3'd6, 3'd4, 32'h11A, 2'd1, b + 5);
    tick(); clr();
    drive(1, 3'd7, 3'd5, 32'h11B);
    drive(2, 3'd1, 3'd6, 32'h22C);
    expect_b(3'd1, 3'd6, 32'h22C, 2'd2, b + 6);
    expect_b(3'd7, 3'd5, 32'h11B, 2'd1, b + 7);
    tick(); clr();
    drain(12);

    // Backpressure on FU2: two accepts fill it, third is held until a slot frees
    tick(); b = cyc; clr();
    drive(3, 3'd3, 3'd3, 32'hC3);
    expect_b(3'd3, 3'd3, 32'hC3, 2'd3, b + 2);
    tick(); clr();
    drive(0, 3'd1, 3'd0, 32'hC0);
    drive(2, 3'd2, 3'd2, 32'hC21);
    expect_b(3'd1, 3'd0, 32'hC0, 2'd0, b + 3);
    expect_b(3'd2, 3'd2, 32'hC21, 2'd2, b + 4);
    tick(); clr();
    drive(2, 3'd4, 3'd4, 32'hC22);
    expect_b(3'd4, 3'd4, 32'hC22, 2'd2, b + 5);
    tick(); clr();
    drive(2, 3'd5, 3'd5, 32'hC23);
    expect_b(3'd5, 3'd5, 32'hC23, 2'd2, b + 6);
    @(negedge clock);
    chk("bp_ready_full", 64'(fu_ready[2]), 64'd0);
    tick();
    @(negedge clock);
    chk("bp_ready_reopen", 64'(fu_ready[2]), 64'd1);
    tick(); clr();
    drain(12);

    // Reserved ROB tag 0 is swallowed; the following FU1 result is the only broadcast
    tick(); b = cyc; clr();
    drive(1, 3'd0, 3'd1, 32'hEE);
    tick(); clr();
    drive(1, 3'd6, 3'd2, 32'h66);
    expect_b(3'd6, 3'd2, 32'h66, 2'd1, b + 3);
    tick(); clr();
    drain(10);

    // Squash with four results queued; rr_ptr (=2) must survive
    tick(); b = cyc; clr();
    drive(1, 3'd1, 3'd1, 32'h5A);
    expect_b(3'd1, 3'd1, 32'h5A, 2'd1, b + 2);
    tick(); clr();
    drive(0, 3'd2, 3'd0, 32'hD0);
    drive(1, 3'd3, 3'd1, 32'hD1);
    drive(2, 3'd4, 3'd2, 32'hD2);
    drive(3, 3'd5, 3'd3, 32'hD3);
    tick(); clr();
    squash = 1'b1;
    drive(0, 3'd6, 3'd0, 32'hD4);
    tick(); clr();
    squash = 1'b0;
    @(negedge clock);
    chk("sq_valid", 64'(cdb_valid), 64'd0);
    chk("sq_rob",   64'(cdb_rob_tag), 64'd0);
    chk("sq_ready", 64'(fu_ready), 64'hF);
    repeat (4) tick();
    drain(1);
    tick(); b = cyc; clr();
    drive(1, 3'd3, 3'd1, 32'hE1);
    drive(2, 3'd4, 3'd2, 32'hE2);
    expect_b(3'd4, 3'd2, 32'hE2, 2'd2, b + 2);
    expect_b(3'd3, 3'd1, 32'hE1, 2'd1, b + 3);
    tick(); clr();
    drain(10);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Transmit end of the common data bus (CDB); reservation stations, ROB and map table are the receivers.
- Collects completed results from NUM_FU functional units, buffers each in a small per-FU FIFO, round-robin arbitrates, and broadcasts one result per cycle.
- The registered bus carries ROB tag, RS tag and value.
- Sits between the execute stage and the RS/ROB/map-table CDB inputs.

Parameters:
- NUM_FU, 4, number of functional-unit completion ports (power of two, 2..8)
- QDEPTH, 2, entries per FU FIFO (power of two, >=2)
- ROB_TAG_W, 3, ROB tag width; tag 0 is reserved ("no producer")
- RS_TAG_W, 3, RS entry tag width; value 7 means invalid
- XLEN, 32, result width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- squash  in  1  ROB mispredict flush; synchronous
- fu_valid  in  NUM_FU  per-FU result valid
- fu_ready  out  NUM_FU  per-FU FIFO not full
- fu_rob_tag  in  NUM_FU*ROB_TAG_W  per-FU ROB tag; FU i occupies slice [i*ROB_TAG_W +: ROB_TAG_W]
- fu_rs_tag  in  NUM_FU*RS_TAG_W  per-FU RS entry being freed
- fu_value  in  NUM_FU*XLEN  per-FU result
- cdb_valid  out  1  broadcast valid
- cdb_rob_tag  out  ROB_TAG_W  broadcast ROB tag
- cdb_rs_tag  out  RS_TAG_W  broadcast RS tag
- cdb_value  out  XLEN  broadcast value
- cdb_src  out  $clog2(NUM_FU)  index of the granted FU

Behaviour:
- Reset (async) clears:
  - all FIFO pointers and counts;
  - rr_ptr=0;
  - cdb_valid=0, cdb_rob_tag=0, cdb_rs_tag=7, cdb_value=0, cdb_src=0.
  - fu_ready is all ones once reset deasserts.
- Handshake:
  - fu_ready[i] = (count[i] != QDEPTH). It is driven from registered state only and never depends on fu_valid.
  - A transfer occurs when fu_valid[i] && fu_ready[i]; the tuple is enqueued at that edge.
  - fu_valid with fu_rob_tag==0 is a protocol error. The tuple is accepted and dropped, never broadcast.
- Arbitration, each cycle:
  - Candidates are FIFOs with count>0.
  - Winner is the first candidate scanning rr_ptr, rr_ptr+1, ... modulo NUM_FU.
  - Winner head is dequeued and registered onto cdb_* at the edge.
  - rr_ptr <= (winner+1) mod NUM_FU.
  - No candidate: cdb_valid<=0, cdb_rob_tag<=0, cdb_rs_tag<=7, rr_ptr unchanged.
- Latency (no bypass): handshake in cycle N, enqueue at end of N, eligible in N+1, cdb_valid high in N+2.
- cdb_valid is a single-cycle pulse per result. Receivers have no backpressure.
- Simultaneous enqueue and dequeue on a full FIFO:
  - fu_ready is already 0, so no enqueue happens; count decrements.
  - fu_ready rises the next cycle.
- Simultaneous enqueue and dequeue on a non-full FIFO: count unchanged, order preserved (FIFO).
- Pointer wrap: read/write pointers wrap modulo QDEPTH; count distinguishes full from empty.
- Squash:
  - At the edge, all FIFOs are emptied and rr_ptr is kept.
  - cdb_valid<=0 and cdb_rob_tag<=0 at the same edge.
  - Handshakes in the squash cycle are discarded.
- Reset mid-operation: all queued results are lost and outputs return to reset values immediately.
- When cdb_valid=0, cdb_rob_tag=0, so a receiver comparing tags never matches a live ROB entry.

Optional Feature:
- CDB_BYPASS_EN defined:
  - If FIFO i is empty and fu_valid[i]&&fu_ready[i], FU i's input tuple is a candidate in the same cycle.
  - If it wins, it goes straight to the cdb_* registers and is not enqueued. Latency is 1 cycle (handshake N, cdb_valid in N+1).
  - If it loses, it is enqueued normally.
- CDB_BYPASS_EN undefined: only FIFO heads are candidates; latency is 2 cycles.
- Round-robin order and squash behaviour are identical in both builds.

Test Plan:
- Single result: FU1 sends rob=3, rs=1, value=0xDEAD in cycle 5 -> cdb_valid=1 in cycle 7 (cycle 6 with bypass) with rob=3, rs=1, value=0xDEAD, src=1; cdb_valid=0 in cycle 8.
- Round-robin fairness: after reset, FUs 0, 2 and 3 each send one result in the same cycle -> broadcasts on consecutive cycles in order src 0, 2, 3; rr_ptr ends at 0.
- Backpressure: FU2 sends 3 results back-to-back while FU0 keeps winning, with rr_ptr manipulated so FU2 loses -> fu_ready[2]=0 after 2 accepts; the third result is held by the FU; all 3 eventually broadcast in order.
- Rotation and wrap:
  - FU3 and FU0 pending with rr_ptr=3 -> FU3 granted first, then FU0; rr_ptr wraps to 1.
  - FU1 then has 2 queued results alongside FU2 -> grants alternate 1, 2, 1.
- Squash: 4 results queued across FUs; assert squash for one cycle -> cdb_valid=0 and cdb_rob_tag=0 the next cycle; no queued result is ever broadcast; fu_ready is all ones.
- Reserved tag and reset: fu_rob_tag=0 is never broadcast. Asserting reset while cdb_valid=1 -> cdb_valid=0 and cdb_rs_tag=7 immediately.
